// File: rtl/core_clk_seq_if.sv
// Request/status bundle between the system controller and the core clock sequencer.
// The sequencer takes the slave modport; whoever drives requests takes master.
interface core_clk_seq_if #(
  parameter int unsigned NUM_CORES = 4
);
  logic                 global_enable;
  logic [NUM_CORES-1:0] core_enable;
  logic                 test_mode;
  logic [NUM_CORES-1:0] core_idle;
  logic [NUM_CORES-1:0] core_clk_en;
  logic [NUM_CORES-1:0] core_rst_n;
  logic [NUM_CORES-1:0] core_drain_req;
  logic [NUM_CORES-1:0] drain_timeout;
  logic                 system_ready;

  modport master (
    output global_enable,
    output core_enable,
    output test_mode,
    output core_idle,
    input  core_clk_en,
    input  core_rst_n,
    input  core_drain_req,
    input  drain_timeout,
    input  system_ready
  );

  modport slave (
    input  global_enable,
    input  core_enable,
    input  test_mode,
    input  core_idle,
    output core_clk_en,
    output core_rst_n,
    output core_drain_req,
    output drain_timeout,
    output system_ready
  );
endinterface

// File: rtl/core_clk_seq.sv
// Per-core clock-enable / reset sequencer with staggered start grants, reset hold
// and idle-handshake drain. Outputs feed downstream ICG enables, not gated clocks.
module core_clk_seq #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES   = 16
) (
  input logic           clk_in,
  input logic           rst_n_in,
  core_clk_seq_if.slave bus
);

  localparam int unsigned MaxCnt = (SYNC_STAGES > DRAIN_CYCLES) ? SYNC_STAGES : DRAIN_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned StagW  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  localparam logic [CntW-1:0]  SyncLast  = CntW'(SYNC_STAGES - 1);
  localparam logic [CntW-1:0]  DrainLast = CntW'(DRAIN_CYCLES - 1);
  localparam logic [StagW-1:0] StagLoad  = StagW'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    StOff,
    StClkOn,
    StRun,
    StDrain,
    StRstHold
  } state_e;

  state_e               state_q [NUM_CORES];
  state_e               state_d [NUM_CORES];
  logic [CntW-1:0]      cnt_q   [NUM_CORES];
  logic [CntW-1:0]      cnt_d   [NUM_CORES];
  logic [StagW-1:0]     stag_q, stag_d;
  logic [NUM_CORES-1:0] timeout_q, timeout_d;
  logic                 ready_q, ready_d;

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_taken;
  logic [NUM_CORES-1:0] core_ok;
  logic [NUM_CORES-1:0] clk_en;
  logic [NUM_CORES-1:0] rst_n;
  logic [NUM_CORES-1:0] drain_req;

  assign req = bus.core_enable & {NUM_CORES{bus.global_enable}};

  // Start arbiter: one grant per cycle, lowest index first, gated by the stagger timer.
  always_comb begin
    grant       = '0;
    grant_taken = 1'b0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (!grant_taken && (stag_q == '0) && (state_q[i] == StOff) && req[i]) begin
        grant[i]    = 1'b1;
        grant_taken = 1'b1;
      end
    end
  end

  always_comb begin
    stag_d = stag_q;
    if (grant_taken) begin
      stag_d = StagLoad;
    end else if (stag_q != '0) begin
      stag_d = stag_q - StagW'(1);
    end
  end

  // Per-core power FSM; the counter is reused for reset hold and drain timing.
  always_comb begin
    timeout_d = timeout_q;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StOff: begin
          if (grant[i]) begin
            state_d[i] = StClkOn;
            cnt_d[i]   = '0;
          end
        end
        StClkOn: begin
          // Reset never released here, so a dropped request skips the drain.
          if (!req[i]) begin
            state_d[i] = StOff;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == SyncLast) begin
            state_d[i] = StRun;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StRun: begin
          if (!req[i]) begin
            state_d[i] = StDrain;
            cnt_d[i]   = '0;
          end
        end
        StDrain: begin
          if (bus.core_idle[i]) begin
            state_d[i] = StRstHold;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DrainLast) begin
            state_d[i]   = StRstHold;
            cnt_d[i]     = '0;
            timeout_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StRstHold: begin
          if (cnt_q[i] == SyncLast) begin
            state_d[i] = StOff;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        default: begin
          state_d[i] = StOff;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      core_ok[i] = req[i] ? (state_q[i] == StRun) : (state_q[i] == StOff);
    end
    ready_d = bus.global_enable & (&core_ok);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
      stag_q    <= '0;
      timeout_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      stag_q    <= stag_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
    end
  end

  // Moore decode; test_mode only overrides the clock enables.
  always_comb begin
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      clk_en[i]    = (state_q[i] != StOff) | bus.test_mode;
      rst_n[i]     = (state_q[i] == StRun) | (state_q[i] == StDrain);
      drain_req[i] = (state_q[i] == StDrain);
    end
  end

  assign bus.core_clk_en    = clk_en;
  assign bus.core_rst_n     = rst_n;
  assign bus.core_drain_req = drain_req;
  assign bus.drain_timeout  = timeout_q;
  assign bus.system_ready   = ready_q;

endmodule

// File: tb/tb_core_clk_seq.sv
// Directed bench for core_clk_seq (4 cores, SYNC_STAGES=3, STAGGER=4, DRAIN=16).
module tb_core_clk_seq;

  logic clk_in;
  logic rst_n_in;
  int   checks;
  int   failures;

  core_clk_seq_if #(.NUM_CORES(4)) bus ();

  core_clk_seq #(
    .NUM_CORES     (4),
    .SYNC_STAGES   (3),
    .STAGGER_CYCLES(4),
    .DRAIN_CYCLES  (16)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] en_exp;
    logic [3:0] rst_exp;
    logic [3:0] dr_exp;
    logic [3:0] to_exp;
    checks   = 0;
    failures = 0;

    // Reset state
    rst_n_in          = 1'b0;
    bus.global_enable = 1'b0;
    bus.core_enable   = 4'h0;
    bus.test_mode     = 1'b0;
    bus.core_idle     = 4'h0;
    step();
    step();
    chk("rst_clk_en", bus.core_clk_en, 4'h0);
    chk("rst_rst_n", bus.core_rst_n, 4'h0);
    chk("rst_drain_req", bus.core_drain_req, 4'h0);
    chk("rst_timeout", bus.drain_timeout, 4'h0);
    chk("rst_ready", bus.system_ready, 1'b0);
    rst_n_in = 1'b1;
    step();
    chk("idle_ready", bus.system_ready, 1'b0);

    // Staggered start-up of all four cores
    bus.global_enable = 1'b1;
    bus.core_enable   = 4'hF;
    for (int n = 0; n <= 16; n++) begin
      step();
      en_exp  = 4'h0;
      rst_exp = 4'h0;
      for (int j = 0; j < 4; j++) begin
        if (n >= 4 * j) en_exp[j] = 1'b1;
        if (n >= 4 * j + 3) rst_exp[j] = 1'b1;
      end
      chk($sformatf("start_en_%0d", n), bus.core_clk_en, en_exp);
      chk($sformatf("start_rst_%0d", n), bus.core_rst_n, rst_exp);
      chk($sformatf("start_ready_%0d", n), bus.system_ready, (n >= 16) ? 1'b1 : 1'b0);
    end

    // Clean shutdown of core 2, idle sampled at edge 5
    bus.core_enable = 4'b1011;
    for (int n = 0; n <= 9; n++) begin
      step();
      en_exp  = 4'b1011 | ((n < 8) ? 4'b0100 : 4'b0000);
      rst_exp = 4'b1011 | ((n < 5) ? 4'b0100 : 4'b0000);
      dr_exp  = (n <= 4) ? 4'b0100 : 4'b0000;
      chk($sformatf("shut_en_%0d", n), bus.core_clk_en, en_exp);
      chk($sformatf("shut_rst_%0d", n), bus.core_rst_n, rst_exp);
      chk($sformatf("shut_drain_%0d", n), bus.core_drain_req, dr_exp);
      chk($sformatf("shut_ready_%0d", n), bus.system_ready, (n >= 9) ? 1'b1 : 1'b0);
      if (n == 4) bus.core_idle = 4'b0100;
    end
    chk("shut_timeout", bus.drain_timeout, 4'h0);
    bus.core_idle = 4'h0;

    // Drain timeout on core 1
    bus.core_enable = 4'b1001;
    for (int n = 0; n <= 19; n++) begin
      step();
      en_exp  = 4'b1001 | ((n < 19) ? 4'b0010 : 4'b0000);
      rst_exp = 4'b1001 | ((n < 16) ? 4'b0010 : 4'b0000);
      dr_exp  = (n < 16) ? 4'b0010 : 4'b0000;
      to_exp  = (n >= 16) ? 4'b0010 : 4'b0000;
      chk($sformatf("tmo_en_%0d", n), bus.core_clk_en, en_exp);
      chk($sformatf("tmo_rst_%0d", n), bus.core_rst_n, rst_exp);
      chk($sformatf("tmo_drain_%0d", n), bus.core_drain_req, dr_exp);
      chk($sformatf("tmo_flag_%0d", n), bus.drain_timeout, to_exp);
    end

    // Abort core 1 during CLK_ON; core 2 still waits out the stagger window
    bus.core_enable = 4'hF;
    for (int n = 0; n <= 8; n++) begin
      step();
      en_exp  = 4'b1001 | ((n == 0) ? 4'b0010 : 4'b0000) | ((n >= 4) ? 4'b0100 : 4'b0000);
      rst_exp = 4'b1001 | ((n >= 7) ? 4'b0100 : 4'b0000);
      chk($sformatf("abort_en_%0d", n), bus.core_clk_en, en_exp);
      chk($sformatf("abort_rst_%0d", n), bus.core_rst_n, rst_exp);
      chk($sformatf("abort_flag_%0d", n), bus.drain_timeout, 4'b0010);
      chk($sformatf("abort_ready_%0d", n), bus.system_ready, (n >= 8) ? 1'b1 : 1'b0);
      if (n == 0) bus.core_enable = 4'b1101;
    end

    // Restart core 1: sticky timeout survives
    bus.core_enable = 4'hF;
    for (int n = 0; n < 4; n++) step();
    chk("restart_rst", bus.core_rst_n, 4'hF);
    chk("restart_flag", bus.drain_timeout, 4'b0010);
    step();
    chk("restart_ready", bus.system_ready, 1'b1);

    // global_enable drop drains every core
    bus.global_enable = 1'b0;
    step();
    chk("gdrop_drain", bus.core_drain_req, 4'hF);
    chk("gdrop_ready", bus.system_ready, 1'b0);
    chk("gdrop_rst", bus.core_rst_n, 4'hF);
    bus.core_idle = 4'hF;
    step();
    chk("gdrop_hold_rst", bus.core_rst_n, 4'h0);
    chk("gdrop_hold_drain", bus.core_drain_req, 4'h0);
    chk("gdrop_hold_en", bus.core_clk_en, 4'hF);
    step();
    step();
    step();
    chk("gdrop_off_en", bus.core_clk_en, 4'h0);
    bus.test_mode = 1'b1;
    #1;
    chk("tmode_en", bus.core_clk_en, 4'hF);
    chk("tmode_rst", bus.core_rst_n, 4'h0);
    bus.test_mode = 1'b0;
    bus.core_idle = 4'h0;

    // Synchronous reset in the middle of a drain
    bus.global_enable = 1'b1;
    bus.core_enable   = 4'b0001;
    for (int n = 0; n < 4; n++) step();
    chk("mid_run_rst", bus.core_rst_n, 4'b0001);
    bus.core_enable = 4'b0000;
    step();
    chk("mid_drain", bus.core_drain_req, 4'b0001);
    chk("mid_flag", bus.drain_timeout, 4'b0010);
    rst_n_in = 1'b0;
    #2;
    rst_n_in = 1'b1;
    chk("pulse_drain_now", bus.core_drain_req, 4'b0001);
    step();
    chk("pulse_drain", bus.core_drain_req, 4'b0001);
    chk("pulse_rst", bus.core_rst_n, 4'b0001);
    bus.test_mode = 1'b1;
    rst_n_in      = 1'b0;
    step();
    chk("mreset_en_tm", bus.core_clk_en, 4'hF);
    chk("mreset_rst", bus.core_rst_n, 4'h0);
    chk("mreset_drain", bus.core_drain_req, 4'h0);
    chk("mreset_flag", bus.drain_timeout, 4'h0);
    chk("mreset_ready", bus.system_ready, 1'b0);
    bus.test_mode = 1'b0;
    #1;
    chk("mreset_en", bus.core_clk_en, 4'h0);
    rst_n_in = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
